// File: rtl/dmem_loader.sv
// dmem_loader: streams matrix1 and matrix2 into CPU data memory over a valid/ready
//   word interface, zero-fills the result region, then releases the CPU from reset.
// Latency: a word accepted at edge k is written during cycle k+1 (registered write port);
//   with in_valid held high, loaded rises 1 + IN_WORDS + RES_WORDS + 1 cycles after start.
// Backpressure: in_ready is high throughout LOAD; gaps in in_valid simply stall the stream.
//
// Memory layout (word addresses):
//   0 .. M*N-1                     matrix1, row-major
//   M*N .. IN_WORDS-1              matrix2, row-major
//   IN_WORDS .. IN_WORDS+RES_WORDS-1  result region, zero-filled
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle load request (honoured in IDLE, DONE, ERROR)
//   in_valid   in   source has a word on in_data
//   in_data    in   streamed word (two's complement)
//   in_ready   out  loader accepts a word this cycle
//   mem_we     out  data-memory write enable
//   mem_addr   out  data-memory word address
//   mem_wdata  out  data-memory write data
//   cpu_rst    out  holds the CPU in reset (low only in DONE)
//   loaded     out  memory image complete, CPU released
//   busy       out  high in LOAD or CLEAR
//   error      out  checksum mismatch
//
// Optional feature: define DMEM_LOADER_CHECKSUM_EN to make LOAD accept one trailer word
// after the data words. The trailer is compared with the running sum (mod 2^WIDTH) of the
// data words: a match continues to CLEAR, a mismatch parks in ERROR. Without the macro no
// trailer is accepted, no sum register exists and error is constant 0.

module dmem_loader #(
    parameter int M      = 100,
    parameter int N      = 50,
    parameter int N2     = 2,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              cpu_rst,
    output logic              loaded,
    output logic              busy,
    output logic              error
);

    localparam int IN_WORDS  = M * N + N * N2;
    localparam int RES_WORDS = M * N2;
    localparam int TOTAL     = IN_WORDS + RES_WORDS;

    // One extra counter bit so the counter can hold TOTAL even when TOTAL == 2^ADDR_W.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] C_LAST_IN = CW'(IN_WORDS - 1);
    localparam logic [CW-1:0] C_IN      = CW'(IN_WORDS);
    localparam logic [CW-1:0] C_TOTAL   = CW'(TOTAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;

    logic w_xfer;
    logic w_data_xfer;
    logic w_clr_wr;
    logic w_enter_load;

    // Any accepted word; in_ready is decoded purely from state.
    assign w_xfer       = in_valid && (r_state == S_LOAD);
    // Accepted words that go to memory (the checksum trailer, when present, does not).
    assign w_data_xfer  = w_xfer && (r_cnt < C_IN);
    // CLEAR writes until the counter reaches TOTAL; the cycle at TOTAL lets the last
    // zero write commit before the CPU is released.
    assign w_clr_wr     = (r_state == S_CLEAR) && (r_cnt < C_TOTAL);
    assign w_enter_load = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);

`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] r_sum;
    logic             w_sum_ok;

    assign w_sum_ok = (r_sum == in_data);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_enter_load) begin
            r_sum <= '0;
        end else if (w_data_xfer) begin
            r_sum <= r_sum + in_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        cpu_rst     = 1'b1;
        loaded      = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
`ifdef DMEM_LOADER_CHECKSUM_EN
                if (w_xfer && (r_cnt == C_IN)) begin
                    w_state_nxt = w_sum_ok ? S_CLEAR : S_ERROR;
                end
`else
                if (w_xfer && (r_cnt == C_LAST_IN)) begin
                    w_state_nxt = S_CLEAR;
                end
`endif
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (r_cnt == C_TOTAL) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cpu_rst = 1'b0;
                loaded  = 1'b1;
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_ERROR: begin
`ifdef DMEM_LOADER_CHECKSUM_EN
                error = 1'b1;
`endif
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word counter and registered memory write port. The counter doubles as the write
    // address for both the data stream and the zero fill, so addresses are contiguous
    // and at most one write is issued per cycle.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_enter_load) begin
                r_cnt <= '0;
            end else if (w_data_xfer) begin
                r_we    <= 1'b1;
                r_addr  <= r_cnt[ADDR_W-1:0];
                r_wdata <= in_data;
                r_cnt   <= r_cnt + 1'b1;
            end else if (w_clr_wr) begin
                r_we    <= 1'b1;
                r_addr  <= r_cnt[ADDR_W-1:0];
                r_wdata <= '0;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: randomized self-checking bench for dmem_loader (M=N=N2=2).
// Latency: checks start-to-loaded cycle count for continuous streams.
// Backpressure: drives continuous, alternating and random in_valid patterns.

module tb_dmem_loader;

    localparam int M      = 2;
    localparam int N      = 2;
    localparam int N2     = 2;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 16;
    localparam int IN     = M * N + N * N2;
    localparam int RES    = M * N2;
    localparam int TOT    = IN + RES;
`ifdef DMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              CLOCK_50 = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              cpu_rst;
    logic              loaded;
    logic              busy;
    logic              error;

    dmem_loader #(
        .M(M), .N(N), .N2(N2), .WIDTH(WIDTH), .ADDR_W(ADDR_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .loaded    (loaded),
        .busy      (busy),
        .error     (error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model fed by the write port; cleared whenever the main flow bumps clr_gen.
    logic [WIDTH-1:0] wmem [TOT];
    int               wcnt [TOT];
    int nwr       = 0;
    int bad_addr  = 0;
    int last_addr = -1;
    int first_addr = -1;
    int clr_gen   = 0;
    int seen_gen  = 0;

    always @(negedge CLOCK_50) begin
        if (seen_gen != clr_gen) begin
            seen_gen = clr_gen;
            for (int i = 0; i < TOT; i++) begin
                wmem[i] = 32'hDEAD_BEEF;
                wcnt[i] = 0;
            end
            nwr        = 0;
            bad_addr   = 0;
            first_addr = -1;
        end
        if (!rst && mem_we) begin
            nwr++;
            last_addr = int'(mem_addr);
            if (first_addr < 0) first_addr = int'(mem_addr);
            if (int'(mem_addr) < TOT) begin
                wmem[int'(mem_addr)] = mem_wdata;
                wcnt[int'(mem_addr)]++;
            end else begin
                bad_addr++;
            end
        end
    end

    logic [WIDTH-1:0] words [$];
    int widx = 0;
    int cyc  = 0;

    task automatic tick();
        @(negedge CLOCK_50);
        cyc++;
    endtask

    // Builds the stream: kind 0 = 1..IN, 1 = IN..1, 2 = random; trailer = sum + delta.
    task automatic make_words(input int kind, input logic [WIDTH-1:0] delta);
        logic [WIDTH-1:0] sum;
        sum = '0;
        words.delete();
        for (int i = 0; i < IN; i++) begin
            logic [WIDTH-1:0] w;
            w = (kind == 0) ? WIDTH'(i + 1) : (kind == 1) ? WIDTH'(IN - i) : WIDTH'($urandom);
            words.push_back(w);
            sum = sum + w;
        end
        if (CS != 0) words.push_back(sum + delta);
        widx = 0;
    endtask

    task automatic pulse_start();
        clr_gen++;
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    // mode 0 = continuous valid, 1 = every other cycle, 2 = random gaps.
    task automatic send(input int n, input int mode);
        int   sent;
        int   guard;
        bit   ph;
        logic rdy;
        sent  = 0;
        guard = 0;
        ph    = 1'b1;
        while (sent < n && guard < 200) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
            ph       = !ph;
            in_data  = words[widx];
            rdy      = in_ready;
            tick();
            guard++;
            if (in_valid && rdy) begin
                sent++;
                widx++;
            end
        end
        in_valid = 1'b0;
        if (sent < n) check("send_timeout", 64'(sent), 64'(n));
    endtask

    task automatic wait_end();
        int guard;
        guard = 0;
        while (!loaded && !error && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("wait_end_timeout", 64'(guard), 64'(0));
    endtask

    task automatic check_image(input string tag);
        int dups;
        dups = 0;
        for (int i = 0; i < TOT; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wmem[i]), (i < IN) ? 64'(words[i]) : 64'(0));
            if (wcnt[i] != 1) dups++;
        end
        check({tag, "_nwrites"}, 64'(nwr), 64'(TOT));
        check({tag, "_dups"}, 64'(dups), 64'(0));
        check({tag, "_badaddr"}, 64'(bad_addr), 64'(0));
        check({tag, "_loaded"}, 64'(loaded), 64'(1));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(1));
        check({tag, "_loaded"}, 64'(loaded), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check_reset_outputs("por");
        tick();
        rst = 1'b0;
        tick();

        // Continuous stream 1..IN.
        make_words(0, '0);
        pulse_start();
        check("stream_ready_t1", 64'(in_ready), 64'(1));
        check("stream_busy_t1", 64'(busy), 64'(1));
        check("stream_cpurst_t1", 64'(cpu_rst), 64'(1));
        send(IN + CS, 0);
        check("stream_ready_drop", 64'(in_ready), 64'(0));
        check("stream_busy_clear", 64'(busy), 64'(1));
        wait_end();
        check("stream_latency", 64'(cyc), 64'(1 + IN + RES + 1 + CS));
        check("stream_ready_done", 64'(in_ready), 64'(0));
        check("stream_busy_done", 64'(busy), 64'(0));
        check_image("stream");

        // Restart from DONE with IN..1.
        make_words(1, '0);
        pulse_start();
        check("restart_loaded", 64'(loaded), 64'(0));
        check("restart_cpu_rst", 64'(cpu_rst), 64'(1));
        send(IN + CS, 0);
        wait_end();
        check_image("restart");

        // Alternating valid.
        make_words(0, '0);
        pulse_start();
        send(IN + CS, 1);
        wait_end();
        check_image("bp");

        // Mid-load start (ignored) then asynchronous reset.
        make_words(2, '0);
        pulse_start();
        send(3, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midstart_ready", 64'(in_ready), 64'(1));
        send(1, 0);
        tick();
        tick();
        check("midstart_addr", 64'(last_addr), 64'(3));
        check("midstart_data", 64'(wmem[3]), 64'(words[3]));
        send(1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        tick();
        widx = 0;
        pulse_start();
        send(IN + CS, 2);
        wait_end();
        check("rewrite_first_addr", 64'(first_addr), 64'(0));
        check_image("rewrite");

        // Random data with random gaps.
        for (int r = 0; r < 3; r++) begin
            make_words(2, '0);
            pulse_start();
            send(IN + CS, 2);
            wait_end();
            check_image($sformatf("rand%0d", r));
        end

`ifdef DMEM_LOADER_CHECKSUM_EN
        // Bad trailer (sum - 1) parks in ERROR without zero fill.
        make_words(0, {WIDTH{1'b1}});
        pulse_start();
        send(IN + 1, 0);
        wait_end();
        check("csum_bad_error", 64'(error), 64'(1));
        check("csum_bad_cpu_rst", 64'(cpu_rst), 64'(1));
        check("csum_bad_loaded", 64'(loaded), 64'(0));
        tick();
        tick();
        tick();
        check("csum_bad_nwrites", 64'(nwr), 64'(IN));
        check("csum_bad_hold", 64'(error), 64'(1));
        make_words(0, '0);
        pulse_start();
        check("csum_restart_error", 64'(error), 64'(0));
        check("csum_restart_ready", 64'(in_ready), 64'(1));
        send(IN + 1, 0);
        wait_end();
        check("csum_good_error", 64'(error), 64'(0));
        check_image("csum_good");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
